// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int MAX_REQ        = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Producers are limited to MAX_REQ, so a fixed-width one-hot is truncated by callers.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        logic [MAX_REQ-1:0] base;
        base = {{(MAX_REQ-1){1'b0}}, 1'b1};
        return base << idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request strictly after 'last', wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               valid,
    output logic [IW-1:0]      sel
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    int unsigned          off_s;
    int unsigned          sel_s;

    // Rotate so bit 0 is the requester after 'last', then take the lowest set bit.
    always_comb begin
        dbl_s = {req, req};
        rot_s = NUM_REQ'(dbl_s >> (32'(last) + 32'd1));
        off_s = 32'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            off_s = rot_s[k] ? 32'(k) : off_s;
        end
        sel_s = (32'(last) + 32'd1 + off_s) % 32'(NUM_REQ);
        sel   = IW'(sel_s);
        valid = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO push port between NUM_REQ producers,
// granting bounded bursts and stalling (without counting) while the FIFO is full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          push,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy
);

    localparam int            IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int            CW       = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      last_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    logic               pick_valid_s;
    logic [IW-1:0]      pick_sel_s;
    logic               owner_req_s;
    logic               push_s;
    logic [DATA_WIDTH-1:0] owner_data_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid_s),
        .sel   (pick_sel_s)
    );

    // Owner's request/data and the push strobe; full only suppresses the write.
    always_comb begin
        owner_req_s  = req[owner_q];
        owner_data_s = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        if (state_q == ST_BURST) begin
            push_s = owner_req_s & ~full;
        end else begin
            push_s = 1'b0;
        end
    end

    // Write-side outputs; data is driven for the owner throughout the burst.
    always_comb begin
        if (push_s) begin
            ack = NUM_REQ'(onehot(owner_q));
        end else begin
            ack = {NUM_REQ{1'b0}};
        end
        if (state_q == ST_BURST) begin
            data_in = owner_data_s;
        end else begin
            data_in = {DATA_WIDTH{1'b0}};
        end
    end

    assign push = push_s;
    assign gnt  = gnt_q;
    assign busy = busy_q;

    // Arbitration FSM: grant in IDLE, count accepted words in BURST, always return via IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= {NUM_REQ{1'b0}};
            owner_q <= {IW{1'b0}};
            last_q  <= LAST_RST;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_q <= ST_BURST;
                        gnt_q   <= NUM_REQ'(onehot(pick_sel_s));
                        owner_q <= pick_sel_s;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (push_s && (cnt_q == CNT_LAST)) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= {NUM_REQ{1'b0}};
                        last_q  <= owner_q;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b0;
                    end else if (push_s) begin
                        cnt_q   <= cnt_q + CW'(1);
                    end else if (!owner_req_s) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= {NUM_REQ{1'b0}};
                        last_q  <= owner_q;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= {NUM_REQ{1'b0}};
                    cnt_q   <= {CW{1'b0}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: default 4x4 instance plus a 2-requester, burst-1 instance.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        push;
    logic [7:0]  data_in;
    logic        busy;

    logic [1:0]  req2;
    logic [15:0] data2;
    logic        full2;
    logic [1:0]  gnt2;
    logic [1:0]  ack2;
    logic        push2;
    logic [7:0]  dout2;
    logic        busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
        .gnt(gnt), .ack(ack), .push(push), .data_in(data_in), .busy(busy)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2), .MAX_BURST(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(data2), .full(full2),
        .gnt(gnt2), .ack(ack2), .push(push2), .data_in(dout2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int idx, input logic [7:0] v);
        req_data[idx*8 +: 8] = v;
    endtask

    task automatic chk_push(input string tag, input int owner, input logic [7:0] d);
        chk({tag, " gnt"},  32'(gnt),  32'(4'b0001 << owner));
        chk({tag, " push"}, 32'(push), 32'd1);
        chk({tag, " ack"},  32'(ack),  32'(4'b0001 << owner));
        chk({tag, " data"}, 32'(data_in), 32'(d));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0; req = 4'd0; req_data = 32'd0; full = 1'b0;
        req2 = 2'd0; data2 = 16'd0; full2 = 1'b0;
        #2;
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst push", 32'(push), 32'd0);
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst data", 32'(data_in), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single requester: two back-to-back bursts with one idle cycle between
        req = 4'b0001; set_word(0, 8'd0); #1;
        chk("t1 idle gnt", 32'(gnt), 32'd0);
        chk("t1 idle push", 32'(push), 32'd0);
        for (int w = 0; w < 4; w++) begin
            tick(); set_word(0, 8'(w)); #1;
            chk_push("t1 b1", 0, 8'(w));
        end
        tick(); set_word(0, 8'd4); #1;
        chk("t1 gap push", 32'(push), 32'd0);
        chk("t1 gap busy", 32'(busy), 32'd0);
        chk("t1 gap gnt", 32'(gnt), 32'd0);
        for (int w = 4; w < 8; w++) begin
            tick(); set_word(0, 8'(w)); #1;
            chk_push("t1 b2", 0, 8'(w));
        end
        tick(); req = 4'b0000; #1;
        chk("t1 end busy", 32'(busy), 32'd0);

        // All requesting: fair rotation 0,1,2,3,0
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 8'hA0 + 8'(i));
        #1;
        chk("t2 idle push", 32'(push), 32'd0);
        g = 0;
        for (int b = 0; b < 5; b++) begin
            for (int w = 0; w < 4; w++) begin
                tick(); #1;
                chk_push("t2 burst", g, 8'hA0 + 8'(g));
            end
            tick(); #1;
            chk("t2 gap push", 32'(push), 32'd0);
            chk("t2 gap gnt", 32'(gnt), 32'd0);
            g = (g + 1) % 4;
        end

        // Requester 2 alone, FIFO full for 5 cycles after 2 words
        req = 4'b0100; set_word(2, 8'h20); #1;
        chk("t3 idle push", 32'(push), 32'd0);
        tick(); #1;
        chk_push("t3 w0", 2, 8'h20);
        tick(); set_word(2, 8'h21); #1;
        chk_push("t3 w1", 2, 8'h21);
        for (int s = 0; s < 5; s++) begin
            tick(); set_word(2, 8'h22); full = 1'b1; #1;
            chk("t3 full push", 32'(push), 32'd0);
            chk("t3 full ack", 32'(ack), 32'd0);
            chk("t3 full gnt", 32'(gnt), 32'b0100);
            chk("t3 full busy", 32'(busy), 32'd1);
        end
        tick(); full = 1'b0; #1;
        chk_push("t3 w2", 2, 8'h22);
        tick(); set_word(2, 8'h23); #1;
        chk_push("t3 w3", 2, 8'h23);
        tick(); req = 4'b0010; set_word(1, 8'h10); #1;
        chk("t3 end busy", 32'(busy), 32'd0);
        chk("t3 end gnt", 32'(gnt), 32'd0);

        // Requester 1 drops request after 2 words, then 0 and 1 compete
        tick(); #1;
        chk_push("t4 w0", 1, 8'h10);
        tick(); set_word(1, 8'h11); #1;
        chk_push("t4 w1", 1, 8'h11);
        tick(); req = 4'b0000; #1;
        chk("t4 drop push", 32'(push), 32'd0);
        chk("t4 drop gnt", 32'(gnt), 32'b0010);
        chk("t4 drop busy", 32'(busy), 32'd1);
        tick(); req = 4'b0011; set_word(0, 8'h40); #1;
        chk("t4 idle busy", 32'(busy), 32'd0);
        chk("t4 idle gnt", 32'(gnt), 32'd0);
        tick(); #1;
        chk_push("t4 regrant", 0, 8'h40);

        // Asynchronous reset mid-burst with requester 3 as owner
        rst_n = 1'b0; #1; rst_n = 1'b1;
        req = 4'b1000; set_word(3, 8'h30); #1;
        chk("t5 post-rst gnt", 32'(gnt), 32'd0);
        chk("t5 post-rst push", 32'(push), 32'd0);
        tick(); #1;
        chk_push("t5 w0", 3, 8'h30);
        tick(); set_word(3, 8'h31); #1;
        chk_push("t5 w1", 3, 8'h31);
        tick(); set_word(3, 8'h32); #1;
        chk_push("t5 w2", 3, 8'h32);
        rst_n = 1'b0; #1;
        chk("t5 rst gnt", 32'(gnt), 32'd0);
        chk("t5 rst push", 32'(push), 32'd0);
        chk("t5 rst ack", 32'(ack), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst data", 32'(data_in), 32'd0);
        tick(); rst_n = 1'b1; #1;
        chk("t5 idle push", 32'(push), 32'd0);
        chk("t5 idle busy", 32'(busy), 32'd0);
        for (int w = 8'h32; w < 8'h36; w++) begin
            tick(); set_word(3, 8'(w)); #1;
            chk_push("t5 fresh", 3, 8'(w));
        end
        tick(); req = 4'b0000; #1;
        chk("t5 end busy", 32'(busy), 32'd0);
        chk("t5 end gnt", 32'(gnt), 32'd0);

        // Two requesters, burst of one: alternating grants, push every other cycle
        req2 = 2'b11; data2 = {8'hB1, 8'hB0}; #1;
        chk("t6 idle push", 32'(push2), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick(); #1;
            if (c % 2 == 0) begin
                g = (c / 2) % 2;
                chk("t6 gnt", 32'(gnt2), 32'(2'b01 << g));
                chk("t6 push", 32'(push2), 32'd1);
                chk("t6 ack", 32'(ack2), 32'(2'b01 << g));
                chk("t6 data", 32'(dout2), 32'(8'hB0 + 8'(g)));
            end else begin
                chk("t6 gap push", 32'(push2), 32'd0);
                chk("t6 gap gnt", 32'(gnt2), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
